motor_cmd_sequencer: RTL and testbench

- Sequences motor command frames onto the single shared UART byte transmitter.
- Replaces the per-direction UART generators and their output mux.
- Takes the waiter state-machine direction code and the 3-bit speed, and emits framed command bytes through a valid/ready byte handshake.
- Inserts a safety STOP frame on any change of motion type, and re-sends the active command periodically as a keep-alive.

---
 rtl/motor_pkg.sv | 38 +++
 rtl/motor_frame_encode.sv | 40 ++++
 rtl/motor_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_motor_cmd_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor command sequencer: waiter direction codes,
// motor command codes and frame constants.
package motor_pkg;

  // Waiter state-machine direction codes
  localparam logic [3:0] DIR_S0 = 4'd0;
  localparam logic [3:0] DIR_S1 = 4'd1;
  localparam logic [3:0] DIR_S2 = 4'd2;
  localparam logic [3:0] DIR_S3 = 4'd3;
  localparam logic [3:0] DIR_S4 = 4'd4;
  localparam logic [3:0] DIR_S5 = 4'd5;
  localparam logic [3:0] DIR_S6 = 4'd6;
  localparam logic [3:0] DIR_S7 = 4'd7;
  localparam logic [3:0] DIR_S8 = 4'd8;

  typedef enum logic [2:0] {
    CMD_STOP       = 3'd0,
    CMD_FWD        = 3'd1,
    CMD_LEFT       = 3'd2,
    CMD_BACK       = 3'd3,
    CMD_RIGHT_BACK = 3'd4
  } cmd_t;

  localparam logic [7:0] HDR       = 8'hA5;
  localparam int         FRAME_LEN = 4;

  // Any unlisted code (idle-type states and undefined 9..15) maps to STOP
  function automatic cmd_t dir_to_cmd(input logic [3:0] dir);
    case (dir)
      DIR_S1, DIR_S3: return CMD_FWD;
      DIR_S2:         return CMD_LEFT;
      DIR_S5, DIR_S7: return CMD_BACK;
      DIR_S6:         return CMD_RIGHT_BACK;
      default:        return CMD_STOP;
    endcase
  endfunction

endpackage

// File: rtl/motor_frame_encode.sv
// Combinational frame byte generator: HDR, CMD, scaled speed, checksum.
module motor_frame_encode
  import motor_pkg::*;
#(
  parameter int SPEED_STEP = 32
) (
  input  cmd_t       i_cmd,
  input  logic [2:0] i_speed,
  input  logic [1:0] i_idx,
  output logic [7:0] o_byte
);

  localparam logic [31:0] STEP = SPEED_STEP;

  logic [31:0] w_prod;
  logic [7:0]  w_spd;
  logic [7:0]  w_cmd;

  assign w_prod = {29'd0, i_speed} * STEP;
  assign w_cmd  = {5'd0, i_cmd};

  // STOP always carries a zero speed byte; others saturate at 255
  always_comb begin
    w_spd = 8'h00;
    if (i_cmd != CMD_STOP) w_spd = (w_prod > 32'd255) ? 8'hFF : w_prod[7:0];
  end

  // Byte selection by position within the frame
  always_comb begin
    o_byte = HDR;
    case (i_idx)
      2'd0: o_byte = HDR;
      2'd1: o_byte = w_cmd;
      2'd2: o_byte = w_spd;
      2'd3: o_byte = w_cmd ^ w_spd;
      default: o_byte = HDR;
    endcase
  end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Sequences motor command frames onto the shared UART byte transmitter,
// inserting a STOP frame between motion types and refreshing periodically.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int GAP_CYCLES     = 50000,
  parameter int REFRESH_CYCLES = 5000000,
  parameter int SPEED_STEP     = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_direction,
  input  logic [2:0] i_speed,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [2:0] o_active_cmd
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_MAX  = REF_W'(REFRESH_CYCLES);
  localparam logic [1:0]       IDX_LAST = 2'(FRAME_LEN - 1);

  state_t           r_state, w_next;
  logic [3:0]       r_dir;
  logic [2:0]       r_spd;
  logic             r_pend;
  cmd_t             r_last_cmd, r_frm_cmd, r_active;
  logic [2:0]       r_last_spd, r_frm_spd;
  logic [1:0]       r_idx;
  logic [GAP_W-1:0] r_gap;
  logic [REF_W-1:0] r_ref;
  logic             r_done;

  cmd_t       w_des_cmd;
  logic [2:0] w_des_spd;
  logic       w_need_stop, w_change, w_ref_exp, w_go, w_acc, w_last, w_gap_end;
  logic [7:0] w_byte;

  assign w_des_cmd   = dir_to_cmd(r_dir);
  assign w_des_spd   = (w_des_cmd == CMD_STOP) ? 3'd0 : r_spd;
  assign w_need_stop = r_pend | ((w_des_cmd != r_last_cmd) &&
                                 (w_des_cmd != CMD_STOP) && (r_last_cmd != CMD_STOP));
  assign w_change    = {w_des_cmd, w_des_spd} != {r_last_cmd, r_last_spd};
  assign w_ref_exp   = (r_ref == REF_MAX);
  assign w_go        = w_need_stop | w_change | w_ref_exp;
  assign w_acc       = (r_state == S_SEND) & i_tx_ready;
  assign w_last      = w_acc & (r_idx == IDX_LAST);
  assign w_gap_end   = (r_gap >= GAP_LAST);

  motor_frame_encode #(.SPEED_STEP(SPEED_STEP)) u_enc (
    .i_cmd   (r_frm_cmd),
    .i_speed (r_frm_spd),
    .i_idx   (r_idx),
    .o_byte  (w_byte)
  );

  assign o_tx_valid   = (r_state == S_SEND);
  assign o_tx_data    = (r_state == S_SEND) ? w_byte : 8'h00;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_done;
  assign o_active_cmd = r_active;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_go) w_next = S_LOAD;
      S_LOAD: w_next = S_SEND;
      S_SEND: if (w_last) w_next = S_GAP;
      S_GAP:  if (w_gap_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Input sampling, frame latch, handshake, counters and bookkeeping.
  // The frame content is captured at the IDLE decision so the STOP/no-STOP
  // choice and the transmitted pair always come from the same sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir      <= 4'd0;
      r_spd      <= 3'd0;
      r_pend     <= 1'b1;
      r_last_cmd <= CMD_STOP;
      r_last_spd <= 3'd0;
      r_frm_cmd  <= CMD_STOP;
      r_frm_spd  <= 3'd0;
      r_active   <= CMD_STOP;
      r_idx      <= 2'd0;
      r_gap      <= '0;
      r_ref      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_dir  <= i_direction;
      r_spd  <= i_speed;
      r_done <= w_last;
      if (r_state == S_IDLE && w_go) begin
        r_frm_cmd <= w_need_stop ? CMD_STOP : w_des_cmd;
        r_frm_spd <= w_need_stop ? 3'd0 : w_des_spd;
        if (w_need_stop) r_pend <= 1'b1;
      end
      if (r_state == S_LOAD) r_idx <= 2'd0;
      if (w_acc) r_idx <= r_idx + 2'd1;
      if (w_last) begin
        r_last_cmd <= r_frm_cmd;
        r_last_spd <= r_frm_spd;
        r_active   <= r_frm_cmd;
        if (r_frm_cmd == CMD_STOP) r_pend <= 1'b0;
      end
      r_gap <= (r_state == S_GAP && !w_gap_end) ? r_gap + GAP_W'(1) : '0;
      r_ref <= (r_state == S_IDLE && !w_ref_exp) ? r_ref + REF_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Self-checking bench: transaction-level model of expected frames, random
// stimulus and random tx_ready back-pressure.
module tb_motor_cmd_sequencer;

  localparam int GAP  = 12;
  localparam int REF  = 400;
  localparam int STEP = 32;
  localparam int TMO  = 600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] direction;
  logic [2:0] speed;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid, busy, frame_done;
  logic [2:0] active_cmd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_mode = 1'b0;

  logic [7:0]  byte_q[$];
  logic [31:0] exp_q[$];
  int          first_t[256];
  int          done_t[256];
  int          frm_cnt = 0;
  int          done_cnt = 0;
  logic [2:0]  m_last_c;
  int          m_last_s;

  motor_cmd_sequencer #(.GAP_CYCLES(GAP), .REFRESH_CYCLES(REF), .SPEED_STEP(STEP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_direction(direction), .i_speed(speed),
    .i_tx_ready(tx_ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .o_busy(busy), .o_frame_done(frame_done), .o_active_cmd(active_cmd)
  );

  always #5 clk = ~clk;

  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_cmd(input int d);
    case (d)
      1, 3:    return 3'd1;
      2:       return 3'd2;
      5, 7:    return 3'd3;
      6:       return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_frame(input logic [2:0] c, input int s);
    int v;
    logic [7:0] sb;
    v = (c == 3'd0) ? 0 : s * STEP;
    if (v > 255) v = 255;
    sb = 8'(v);
    return {8'hA5, 5'd0, c, sb, {5'd0, c} ^ sb};
  endfunction

  // Model: queue the frames a new stable input pair must produce
  task automatic apply(input int d, input int s);
    logic [2:0] c;
    int se;
    c  = m_cmd(d);
    se = (c == 3'd0) ? 0 : s;
    if (c != m_last_c && c != 3'd0 && m_last_c != 3'd0) exp_q.push_back(m_frame(3'd0, 0));
    if (c != m_last_c || se != m_last_s) exp_q.push_back(m_frame(c, se));
    m_last_c = c;
    m_last_s = se;
    direction = 4'(d);
    speed = 3'(s);
  endtask

  task automatic get_frame(input string tag);
    logic [31:0] got, exp;
    int n;
    n = 0;
    exp = exp_q.pop_front();
    while (byte_q.size() < 4 && n < TMO) begin @(negedge clk); n++; end
    if (byte_q.size() < 4) begin
      chk({tag, "_timeout"}, byte_q.size(), 4);
    end else begin
      got[31:24] = byte_q.pop_front();
      got[23:16] = byte_q.pop_front();
      got[15:8]  = byte_q.pop_front();
      got[7:0]   = byte_q.pop_front();
      chk(tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) get_frame(tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_hdr(input string tag, input int fidx);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (tx_valid && tx_data == 8'hA5 && (fidx < 0 || frm_cnt == fidx)) break;
    end
    chk(tag, tx_valid, 1);
  endtask

  // Ready driver: always high, or ~30% high when randomized
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Monitor: collects accepted bytes, checks hold-while-stalled and active_cmd
  initial begin
    int bidx;
    bit pv, pr;
    logic [7:0] pd, cur_cmd, last_cmd;
    bidx = 0; pv = 0; pr = 0; pd = 0; cur_cmd = 0; last_cmd = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        bidx = 0; pv = 0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", tx_valid, 1);
          chk("hold_data", tx_data, pd);
        end
        if (frame_done) begin
          done_t[done_cnt % 256] = cyc;
          done_cnt++;
          chk("active_cmd", active_cmd, last_cmd[2:0]);
        end
        if (tx_valid && tx_ready) begin
          if (bidx == 0) first_t[frm_cnt % 256] = cyc;
          if (bidx == 1) cur_cmd = tx_data;
          byte_q.push_back(tx_data);
          bidx = (bidx + 1) % 4;
          if (bidx == 0) begin frm_cnt++; last_cmd = cur_cmd; end
        end
        pv = tx_valid; pr = tx_ready; pd = tx_data;
      end
    end
  end

  initial begin
    int k0, dt, d, s, se, s_r;
    logic [2:0] c;
    rst_n = 1'b0; direction = 4'd0; speed = 3'd0;
    m_last_c = 3'd0; m_last_s = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_active_cmd", active_cmd, 0);
    rst_n = 1'b1;

    // First frame after reset is STOP; next only at refresh
    exp_q.push_back(m_frame(3'd0, 0));
    drain("first_stop");
    exp_q.push_back(m_frame(3'd0, 0));
    drain("refresh_stop");
    dt = first_t[1] - done_t[0];
    chk("refresh_interval", (dt >= REF && dt <= REF + GAP + 8), 1);
    wait_idle("idle_after_refresh");

    // FWD speed 3: valid exactly 3 clocks after the input change, no STOP
    apply(1, 3);
    @(posedge clk); #1 chk("lat_c1", tx_valid, 0);
    @(posedge clk); #1 chk("lat_c2", tx_valid, 0);
    @(posedge clk); #1 chk("lat_c3", tx_valid, 1);
    chk("fwd_frame_exp", exp_q.size(), 1);
    drain("fwd3");

    // FWD -> BACK inserts STOP, then BACK after the gap
    k0 = frm_cnt;
    apply(5, 7);
    drain("fwd_to_back");
    dt = first_t[(k0 + 1) % 256] - done_t[k0 % 256];
    chk("gap_respected", dt >= GAP, 1);

    // Input changes mid-SEND are ignored; LEFT never sent
    k0 = frm_cnt;
    apply(1, 2);
    wait_hdr("midsend_start", k0 + 1);
    direction = 4'd2;
    @(negedge clk);
    apply(6, 5);
    drain("midsend");
    wait_idle("idle_after_midsend");
    repeat (20) @(negedge clk);
    chk("no_left_frame", byte_q.size(), 0);

    // Random commands with random back-pressure
    rnd_mode = 1'b1;
    for (int it = 0; it < 14; it++) begin
      do begin
        d = $urandom_range(0, 15);
        s = $urandom_range(0, 7);
        c = m_cmd(d);
        se = (c == 3'd0) ? 0 : s;
      end while (c == m_last_c && se == m_last_s);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      apply(d, s);
      drain("rand_frame");
    end
    rnd_mode = 1'b0;

    // Reset on the 2nd byte of a frame
    wait_idle("idle_before_reset");
    s_r = (m_last_c == 3'd1 && m_last_s == 1) ? 4 : 1;
    direction = 4'd3; speed = 3'(s_r);
    wait_hdr("reset_frame_start", -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_active", active_cmd, 0);
    repeat (3) @(negedge clk);
    byte_q.delete();
    exp_q.delete();
    m_last_c = 3'd0; m_last_s = 0;
    exp_q.push_back(m_frame(3'd0, 0));
    exp_q.push_back(m_frame(3'd1, s_r));
    m_last_c = 3'd1; m_last_s = s_r;
    rst_n = 1'b1;
    drain("post_reset");

    wait_idle("final_idle");
    repeat (20) @(negedge clk);
    chk("final_no_extra", byte_q.size(), 0);
    chk("done_vs_frames", done_cnt, frm_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
